// File: rtl/game_pkg.sv
// Shared screen-state encoding and default timing constants for the game top,
// the object mux and the score logic.
package game_pkg;

   typedef enum logic [2:0] {
      ST_START  = 3'd0,
      ST_PLAY   = 3'd1,
      ST_FREEZE = 3'd2,
      ST_WIN    = 3'd3,
      ST_LOSE   = 3'd4
   } screen_state_t;

   localparam int LIVES_INIT_DEF    = 3;
   localparam int FREEZE_FRAMES_DEF = 60;
   localparam int END_FRAMES_DEF    = 120;

   // States in which startOfFrame pulses advance the frame counter.
   function automatic logic is_counting(screen_state_t s);
      return (s == ST_FREEZE) || (s == ST_WIN) || (s == ST_LOSE);
   endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Game-control bundle between the screen sequencer and the rest of the game.
// Inputs are plain pulses/levels; every output is a registered-state decode.
interface screen_sequencer_if;
   import game_pkg::*;

   logic          startOfFrame;
   logic          enterKey;
   logic          playerHit;
   logic          levelComplete;
   logic          start;
   logic          win;
   logic          lose;
   logic          playEnable;
   logic          freeze;
   logic          newGame;
   logic [1:0]    lives;
   screen_state_t state;

   modport master (
      output startOfFrame, enterKey, playerHit, levelComplete,
      input  start, win, lose, playEnable, freeze, newGame, lives, state
   );

   modport slave (
      input  startOfFrame, enterKey, playerHit, levelComplete,
      output start, win, lose, playEnable, freeze, newGame, lives, state
   );

endinterface

// File: rtl/frame_counter.sv
// 8-bit frame counter: clear has priority, increments saturate at limit.
module frame_counter (
   input  logic       clk,
   input  logic       resetN,
   input  logic       clear,
   input  logic       inc,
   input  logic [7:0] limit,
   output logic [7:0] count
);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         count <= 8'd0;
      end else if (clear) begin
         count <= 8'd0;
      end else if (inc && (count < limit)) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/screen_sequencer.sv
// Game screen FSM: start / play / post-hit freeze / win / lose, with lives
// bookkeeping and a one-cycle newGame pulse when a game is launched.
module screen_sequencer
   import game_pkg::*;
#(
   parameter int LIVES_INIT    = LIVES_INIT_DEF,
   parameter int FREEZE_FRAMES = FREEZE_FRAMES_DEF,
   parameter int END_FRAMES    = END_FRAMES_DEF
) (
   input  logic               clk,
   input  logic               resetN,
   screen_sequencer_if.slave  bus
);

   localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
   localparam logic [7:0] FREEZE_LIM = 8'(FREEZE_FRAMES);
   localparam logic [7:0] END_LIM    = 8'(END_FRAMES);

   screen_state_t state_q, state_d;
   logic [1:0]    lives_q, lives_d;
   logic          key_q;
   logic          new_game_q, new_game_d;
   logic [7:0]    frame_count;
   logic          key_press;
   logic          count_clear;
   logic          count_inc;
   logic [7:0]    count_limit;

   assign key_press = bus.enterKey & ~key_q;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q    <= ST_START;
         lives_q    <= LIVES_LOAD;
         key_q      <= 1'b1;
         new_game_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         key_q      <= bus.enterKey;
         new_game_q <= new_game_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      new_game_d = 1'b0;
      case (state_q)
         ST_START: begin
            if (key_press) begin
               state_d    = ST_PLAY;
               lives_d    = LIVES_LOAD;
               new_game_d = 1'b1;
            end
         end
         ST_PLAY: begin
            // A simultaneous win beats the hit and leaves lives untouched.
            if (bus.levelComplete) begin
               state_d = ST_WIN;
            end else if (bus.playerHit) begin
               lives_d = lives_q - 2'd1;
               state_d = (lives_q == 2'd1) ? ST_LOSE : ST_FREEZE;
            end
         end
         ST_FREEZE: begin
            if (bus.startOfFrame && (frame_count == FREEZE_LIM - 8'd1)) begin
               state_d = ST_PLAY;
            end
         end
         ST_WIN, ST_LOSE: begin
            if (key_press && (frame_count == END_LIM)) begin
               state_d = ST_START;
            end
         end
         default: state_d = ST_START;
      endcase
   end

   // Clearing on every transition also drops a frame pulse that coincides with it.
   assign count_clear = (state_d != state_q);
   assign count_inc   = bus.startOfFrame & is_counting(state_q);
   assign count_limit = (state_q == ST_FREEZE) ? FREEZE_LIM : END_LIM;

   frame_counter u_frame_counter (
      .clk    (clk),
      .resetN (resetN),
      .clear  (count_clear),
      .inc    (count_inc),
      .limit  (count_limit),
      .count  (frame_count)
   );

   assign bus.start      = (state_q == ST_START);
   assign bus.win        = (state_q == ST_WIN);
   assign bus.lose       = (state_q == ST_LOSE);
   assign bus.playEnable = (state_q == ST_PLAY);
   assign bus.freeze     = (state_q == ST_FREEZE);
   assign bus.newGame    = new_game_q;
   assign bus.lives      = lives_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: directed game scenarios push the expected output
// vector and the cycle it must appear in; a monitor checks every output change.
module tb_screen_sequencer;
   import game_pkg::*;

   localparam int W = 40;

   logic clk = 1'b0;
   logic resetN;
   bit   key_lvl;

   screen_sequencer_if bus();

   screen_sequencer #(
      .LIVES_INIT    (3),
      .FREEZE_FRAMES (60),
      .END_FRAMES    (120)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int compared   = 0;
   int mismatched = 0;

   function automatic logic [7:0] vec(bit s, bit w, bit l, bit pe, bit fr, bit ng,
                                      logic [1:0] lv);
      return {s, w, l, pe, fr, ng, lv};
   endfunction

   function automatic logic [7:0] outs();
      return {bus.start, bus.win, bus.lose, bus.playEnable, bus.freeze,
              bus.newGame, bus.lives};
   endfunction

   task automatic expect_at(input int unsigned offset, input logic [7:0] v);
      exp_q.push_back({32'(cyc + offset), v});
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input bit sof, input bit key, input bit hit, input bit lc);
      @(negedge clk);
      bus.startOfFrame  = sof;
      bus.enterKey      = key;
      bus.playerHit     = hit;
      bus.levelComplete = lc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, key_lvl, 1'b0, 1'b0);
   endtask

   task automatic frames(input int n, input bit has_exp, input logic [7:0] v);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, key_lvl, 1'b0, 1'b0);
         if (has_exp && (i == n - 1)) expect_at(1, v);
         drive(1'b0, key_lvl, 1'b0, 1'b0);
      end
   endtask

   task automatic press(input bit has_exp, input logic [7:0] v);
      key_lvl = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      key_lvl = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      if (has_exp) expect_at(1, v);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic press_new_game();
      key_lvl = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      key_lvl = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      expect_at(1, vec(0, 0, 0, 1, 0, 1, 2'd3));
      expect_at(2, vec(0, 0, 0, 1, 0, 0, 2'd3));
      drive(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic hit(input bit sof, input bit lc, input logic [7:0] v);
      drive(sof, key_lvl, 1'b1, lc);
      expect_at(1, v);
      drive(1'b0, key_lvl, 1'b0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [7:0]   prev;
      logic [7:0]   cur;
      logic [W-1:0] e;
      prev = 'x;
      @(posedge clk);
      forever begin
         @(negedge clk);
         cur = outs();
         if (cur !== prev) begin
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_change cyc=%0d got=%b state=%s required=no change",
                        cyc, cur, bus.state.name());
            end else begin
               e = exp_q.pop_front();
               if ((e[7:0] !== cur) || (e[39:8] !== cyc)) begin
                  mismatched++;
                  $display("FAIL transition cyc=%0d got=%b state=%s required=%b at cyc=%0d",
                           cyc, cur, bus.state.name(), e[7:0], e[39:8]);
               end
            end
            prev = cur;
         end
         compared++;
         if (($countones({bus.start, bus.win, bus.lose}) > 1) ||
             (bus.playEnable && bus.freeze)) begin
            mismatched++;
            $display("FAIL exclusion cyc=%0d got=%b required=one screen, not play+freeze",
                     cyc, cur);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      resetN            = 1'b0;
      key_lvl           = 1'b1;
      bus.startOfFrame  = 1'b0;
      bus.enterKey      = 1'b1;
      bus.playerHit     = 1'b0;
      bus.levelComplete = 1'b0;
      expect_at(1, vec(1, 0, 0, 0, 0, 0, 2'd3));
      idle(2);
      resetN = 1'b1;
      idle(4);

      // New game, then three hits down to LOSE.
      press_new_game();
      idle(3);
      hit(1'b1, 1'b0, vec(0, 0, 0, 0, 1, 0, 2'd2));
      idle(2);
      drive(1'b0, key_lvl, 1'b1, 1'b1);
      drive(1'b0, key_lvl, 1'b0, 1'b0);
      frames(60, 1'b1, vec(0, 0, 0, 1, 0, 0, 2'd2));
      idle(2);
      hit(1'b0, 1'b0, vec(0, 0, 0, 0, 1, 0, 2'd1));
      frames(60, 1'b1, vec(0, 0, 0, 1, 0, 0, 2'd1));
      idle(2);
      hit(1'b0, 1'b0, vec(0, 0, 1, 0, 0, 0, 2'd0));
      idle(2);
      press(1'b0, 8'd0);
      frames(120, 1'b0, 8'd0);
      press(1'b1, vec(1, 0, 0, 0, 0, 0, 2'd0));
      idle(2);

      // Second game: two hits, then hit and win together at one life.
      press_new_game();
      hit(1'b0, 1'b0, vec(0, 0, 0, 0, 1, 0, 2'd2));
      frames(60, 1'b1, vec(0, 0, 0, 1, 0, 0, 2'd2));
      hit(1'b0, 1'b0, vec(0, 0, 0, 0, 1, 0, 2'd1));
      frames(60, 1'b1, vec(0, 0, 0, 1, 0, 0, 2'd1));
      idle(2);
      hit(1'b0, 1'b1, vec(0, 1, 0, 0, 0, 0, 2'd1));

      // WIN screen: early presses and a held key must not leave it.
      frames(50, 1'b0, 8'd0);
      press(1'b0, 8'd0);
      frames(69, 1'b0, 8'd0);
      press(1'b0, 8'd0);
      frames(1, 1'b0, 8'd0);
      frames(10, 1'b0, 8'd0);
      press(1'b1, vec(1, 0, 0, 0, 0, 0, 2'd1));
      idle(2);

      // Reset during FREEZE with the key held high.
      press_new_game();
      hit(1'b0, 1'b0, vec(0, 0, 0, 0, 1, 0, 2'd2));
      frames(5, 1'b0, 8'd0);
      drive(1'b0, key_lvl, 1'b0, 1'b0);
      resetN = 1'b0;
      expect_at(1, vec(1, 0, 0, 0, 0, 0, 2'd3));
      drive(1'b0, key_lvl, 1'b0, 1'b0);
      resetN = 1'b1;
      idle(6);
      press_new_game();
      idle(4);

      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain got=%0d pending transitions required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at new game, range 1..3.
REQ-002 SHALL have parameter FREEZE_FRAMES, default 60: frames of freeze after a hit, range 1..255.
REQ-003 SHALL have parameter END_FRAMES, default 120: minimum frames a win/lose screen shows before a key is accepted, range 1..255.
REQ-004 SHALL have port clk  input  1  system clock; single clock domain.
REQ-005 SHALL have port resetN  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port startOfFrame  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port enterKey  input  1  key level, already synchronous to clk.
REQ-008 SHALL have port playerHit  input  1  one-cycle pulse: player collided with a ghost.
REQ-009 SHALL have port levelComplete  input  1  one-cycle pulse: win condition met.
REQ-010 SHALL have port start  output  1  start screen active; drives the mux start input.
REQ-011 SHALL have port win  output  1  win screen active.
REQ-012 SHALL have port lose  output  1  lose screen active.
REQ-013 SHALL have port playEnable  output  1  movement/game logic may advance.
REQ-014 SHALL have port freeze  output  1  post-hit freeze in progress.
REQ-015 SHALL have port newGame  output  1  one-cycle pulse clearing score and object positions.
REQ-016 SHALL have port lives  output  2  remaining lives; drives life-icon drawing.

Function
REQ-017 SHALL implement states START, PLAY, FREEZE, WIN, LOSE; outputs decoded from registered state only (Moore).
REQ-018 SHALL detect keyPress as the rising edge of enterKey, using one registered copy of the key; a key held across a transition SHALL NOT retrigger.
REQ-019 START: start=1; on keyPress go to PLAY, load lives=LIVES_INIT, assert newGame for exactly the one cycle in which the transition is taken.
REQ-020 PLAY: playEnable=1; on playerHit decrement lives; if the result is 0 go to LOSE, else go to FREEZE.
REQ-021 PLAY: on levelComplete go to WIN; if levelComplete and playerHit arrive in the same cycle, levelComplete wins and lives are unchanged.
REQ-022 FREEZE: freeze=1, playEnable=0; count startOfFrame pulses and return to PLAY on the pulse making the count equal FREEZE_FRAMES; playerHit and levelComplete are ignored.
REQ-023 WIN/LOSE: win=1 or lose=1 respectively; count startOfFrame pulses saturating at END_FRAMES; keyPress is ignored until the count reaches END_FRAMES, then goes to START.
REQ-024 Frame counter: 8-bit, cleared on every state transition; no wrap-around, saturating.
REQ-025 Lives SHALL never underflow; a decrement at lives=0 is impossible by construction (PLAY is not reachable with lives=0).
REQ-026 At most one of start/win/lose SHALL be 1 in any cycle; playEnable and freeze are mutually exclusive.
REQ-027 Response latency: an input sampled at edge N SHALL be reflected on the outputs after edge N (one-cycle registered latency).
REQ-028 startOfFrame coincident with a state transition SHALL NOT be counted in the new state.

Reset
REQ-029 While resetN=0 at a clk edge: state=START, counter=0, lives=LIVES_INIT, key register=1 (a key held through reset is not treated as a press); outputs start=1, win=lose=playEnable=freeze=newGame=0.
REQ-030 Reset mid-game (any state) SHALL take effect at the next clk edge, and no newGame pulse SHALL be generated by the reset itself.

Structure
REQ-031 The state enum and default parameter constants SHALL live in a shared package, game_pkg, for reuse by the object mux top and the score logic.
REQ-032 The frame counter with saturation and clear SHALL be a sub-module, frame_counter; the FSM SHALL stay in screen_sequencer.

Verification
REQ-033 Reset, then enterKey 0->1 -> newGame is a one-cycle pulse, state PLAY, lives=3, playEnable=1.
REQ-034 In PLAY, 3 playerHit pulses each separated by the freeze -> lives 2, then 1, then 0; FREEZE lasts exactly 60 startOfFrame pulses; the third hit goes directly to LOSE (lose=1).
REQ-035 playerHit and levelComplete in the same cycle with lives=1 -> WIN, lives stays 1.
REQ-036 In WIN, keyPress after 50 frames -> ignored; keyPress after 120 frames -> START; enterKey held high continuously -> no transition.
REQ-037 resetN=0 for one cycle during FREEZE -> START next cycle, lives=3, no newGame pulse; mutual-exclusion assertions hold throughout every scenario.
